mem_array: RTL and testbench
============================

Name: mem_array

Overview:
- Parametrised, clocked successor to the 8x8 byte/bit-cell memory: a single-port array of DEPTH words, each WIDTH bits, keeping the inp/rw/sel/outp access style.
- Adds synchronous word addressing, a registered read with a one-cycle out_valid strobe, and a reset-triggered clear sequencer that zeroes every word.
- An out-of-range address flag is included for non-power-of-two depths.
- Sits under the system-level memory controller as the storage core.

Parameters:
- WIDTH, 8, bits per word.
- DEPTH, 8, number of words; any value >= 2.
- AW, $clog2(DEPTH), address width. It is derived; overriding it is not supported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- inp  input  WIDTH  write data.
- addr  input  AW  word address.
- rw  input  1  1 = write, 0 = read; sampled only when sel=1.
- sel  input  1  access request, sampled every rising edge.
- outp  output  WIDTH  registered read data.
- out_valid  output  1  one-cycle strobe: outp was updated by a read.
- busy  output  1  clear sequence in progress; accesses are ignored.
- err  output  1  one-cycle strobe: the last accepted access had addr >= DEPTH.

Behaviour:
- Reset (rst=1 at a clock edge):
  - outp=0, out_valid=0, err=0, busy=1.
  - Clear pointer=0; state goes to CLEAR.
  - Reset takes priority over everything, including a clear already in progress, which restarts from word 0.
- State CLEAR:
  - Each cycle: mem[ptr] <= 0, then ptr <= ptr+1.
  - When ptr==DEPTH-1 the final word is written and the state moves to IDLE.
  - busy=1 for exactly DEPTH cycles after rst deasserts; busy falls on the edge that writes the last word.
  - sel is ignored: no write, outp unchanged, out_valid=0, err=0.
- State IDLE: busy=0. An access is accepted when sel=1 at a rising edge.
- Write (accepted access, rw=1, addr<DEPTH):
  - mem[addr] <= inp.
  - outp unchanged; out_valid=0 next cycle.
- Read (accepted access, rw=0, addr<DEPTH):
  - outp <= mem[addr] at the same edge, visible the next cycle (latency 1).
  - out_valid=1 for that one cycle.
- Read-after-write:
  - A read issued the cycle after a write to the same address returns the new data.
  - No same-cycle read/write is possible: single port.
- Out-of-range (accepted access with addr >= DEPTH; only possible when DEPTH is not a power of 2):
  - A write is discarded.
  - A read forces outp <= 0 with out_valid=1.
  - err=1 for one cycle in both cases.
- sel=0:
  - No state change; outp holds its last value.
  - out_valid=0 and err=0 the next cycle.
- Back-to-back reads issued every cycle produce a continuous out_valid=1, with one word per cycle in issue order.
- No memory contents survive reset; all words read 0 after the clear completes.

Test Plan:
- Pulse rst for 1 cycle, WIDTH=8, DEPTH=8 -> busy=1 for exactly 8 cycles then 0; reads of addresses 0..7 return 8'h00 with out_valid each cycle.
- Write 8'hAA to addr 3, then read addr 3 the next cycle -> outp=8'hAA and out_valid=1 exactly one cycle after the read is issued; outp holds 8'hAA while sel=0.
- Write 8'hCC to addr 5 with sel=0, then read addr 5 -> outp=8'h00, confirming the write was ignored.
- Drive sel=1, rw=1, inp=8'hF0 during CLEAR, then read that address after busy falls -> 8'h00.
- Assert rst at clear cycle 4 of a DEPTH=8 sequence after writing 8'h55 to addr 7 beforehand -> busy stays high for 8 full cycles after the second rst; addr 7 reads 8'h00.
- DEPTH=6: write 8'h11 to addr 6, then read addr 6 -> err=1 on both accesses, the read returns outp=8'h00 with out_valid=1, and addr 0..5 are unchanged.

Source files
------------

// File: rtl/mem_array_if.sv
// mem_array_if: access bus between a memory client and the mem_array storage
// core.
//   inp       - write data                           (master -> slave)
//   addr      - word address                         (master -> slave)
//   rw        - 1 = write, 0 = read, used when sel=1 (master -> slave)
//   sel       - access request, sampled every edge   (master -> slave)
//   outp      - registered read data                 (slave -> master)
//   out_valid - one-cycle strobe, outp updated       (slave -> master)
//   busy      - clear sequence running               (slave -> master)
//   err       - one-cycle strobe, addr was >= DEPTH  (slave -> master)
interface mem_array_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] inp;
  logic [AW-1:0]    addr;
  logic             rw;
  logic             sel;
  logic [WIDTH-1:0] outp;
  logic             out_valid;
  logic             busy;
  logic             err;

  modport master (
    output inp, addr, rw, sel,
    input  outp, out_valid, busy, err
  );

  modport slave (
    input  inp, addr, rw, sel,
    output outp, out_valid, busy, err
  );
endinterface

// File: rtl/mem_array.sv
// mem_array: single-port DEPTH x WIDTH storage core with a registered read
// port and a reset-triggered clear sequencer.
//   clk - rising-edge clock
//   rst - synchronous active-high reset; starts the clear sequence
//   bus - mem_array_if slave port (inp/addr/rw/sel in, outp/out_valid/busy/err out)
// After reset every word is zeroed one per cycle while busy=1; accesses are
// ignored until the clear finishes.
module mem_array #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic       clk,
  input logic       rst,
  mem_array_if.slave bus
);
  localparam int              AW        = $clog2(DEPTH);
  localparam int              LAST      = DEPTH - 1;
  localparam logic [AW-1:0]   LAST_PTR  = LAST[AW-1:0];
  // One extra bit so DEPTH itself is representable for the range compare.
  localparam logic [AW:0]     DEPTH_EXT = DEPTH[AW:0];

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] outp_q, outp_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             in_range;

  assign in_range = {1'b0, bus.addr} < DEPTH_EXT;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    outp_d      = outp_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = bus.addr;
    mem_wdata   = bus.inp;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (bus.sel) begin
          err_d = !in_range;
          if (bus.rw) begin
            // Out-of-range writes are dropped.
            mem_we = in_range;
          end else begin
            out_valid_d = 1'b1;
            outp_d      = in_range ? mem_q[bus.addr] : '0;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    // Reset wins over any write that the current state would perform.
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      outp_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      outp_q      <= outp_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Storage has no reset of its own; the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.outp      = outp_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_mem_array.sv
// tb_mem_array: testbench for mem_array. Two instances: DEPTH=8 (power of two)
// and DEPTH=6 (exercises out-of-range addresses). A behavioural array model
// per instance supplies expected read data and strobes.
module tb_mem_array;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst6;

  mem_array_if #(.WIDTH(8), .DEPTH(8)) bus8 ();
  mem_array_if #(.WIDTH(8), .DEPTH(6)) bus6 ();

  mem_array #(.WIDTH(8), .DEPTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8.slave));
  mem_array #(.WIDTH(8), .DEPTH(6)) dut6 (.clk(clk), .rst(rst6), .bus(bus6.slave));

  int checks = 0;
  int errors = 0;

  logic [7:0] model8 [8];
  logic [7:0] model6 [6];
  logic [7:0] exp_outp8, exp_outp6;
  logic       exp_ov8, exp_err8, exp_ov6, exp_err6;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic s, input logic r, input logic [2:0] a, input logic [7:0] d);
    bus8.sel = s; bus8.rw = r; bus8.addr = a; bus8.inp = d;
  endtask

  task automatic drive6(input logic s, input logic r, input logic [2:0] a, input logic [7:0] d);
    bus6.sel = s; bus6.rw = r; bus6.addr = a; bus6.inp = d;
  endtask

  // One idle-state access on the DEPTH=8 instance plus the model's prediction.
  task automatic step8(input logic s, input logic r, input logic [2:0] a, input logic [7:0] d);
    drive8(s, r, a, d);
    tick();
    exp_ov8  = s && !r;
    exp_err8 = 1'b0;
    if (s && !r) exp_outp8 = model8[a];
    if (s && r)  model8[a] = d;
  endtask

  // Same for the DEPTH=6 instance, where addresses 6 and 7 are out of range.
  task automatic step6(input logic s, input logic r, input logic [2:0] a, input logic [7:0] d);
    drive6(s, r, a, d);
    tick();
    exp_ov6  = s && !r;
    exp_err6 = s && (a >= 3'd6);
    if (s && !r) exp_outp6 = (a < 3'd6) ? model6[a] : 8'h00;
    if (s && r && a < 3'd6) model6[a] = d;
  endtask

  task automatic clear_model8();
    for (int i = 0; i < 8; i++) model8[i] = 8'h00;
    exp_outp8 = 8'h00;
  endtask

  task automatic test_reset();
    int n;
    rst8 = 1'b1;
    drive8(1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    checks++; if (bus8.outp !== 8'h00) begin errors++; $display("[TB] FAIL reset_outp got %h want 00", bus8.outp); end
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ov got %b want 0", bus8.out_valid); end
    checks++; if (bus8.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", bus8.err); end
    checks++; if (bus8.busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy got %b want 1", bus8.busy); end
    rst8 = 1'b0;
    n = 0;
    while (bus8.busy === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (n != 8) begin errors++; $display("[TB] FAIL reset_busy_len got %0d want 8", n); end
    clear_model8();
    for (int i = 0; i < 8; i++) begin
      step8(1'b1, 1'b0, 3'(i), 8'h00);
      checks++; if (bus8.outp !== exp_outp8 || bus8.out_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL reset_readback addr=%0d got %h/%b want %h/1", i, bus8.outp, bus8.out_valid, exp_outp8);
      end
    end
  endtask

  task automatic test_write_read();
    step8(1'b1, 1'b1, 3'd3, 8'hAA);
    checks++; if (bus8.out_valid !== 1'b0 || bus8.outp !== exp_outp8) begin
      errors++; $display("[TB] FAIL wr_strobe got %h/%b want %h/0", bus8.outp, bus8.out_valid, exp_outp8);
    end
    step8(1'b1, 1'b0, 3'd3, 8'h00);
    checks++; if (bus8.outp !== 8'hAA || bus8.out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL raw_read got %h/%b want aa/1", bus8.outp, bus8.out_valid);
    end
    repeat (3) begin
      step8(1'b0, 1'b0, 3'd0, 8'h00);
      checks++; if (bus8.outp !== 8'hAA || bus8.out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL hold_outp got %h/%b want aa/0", bus8.outp, bus8.out_valid);
      end
    end
  endtask

  task automatic test_sel_gate();
    step8(1'b0, 1'b1, 3'd5, 8'hCC);
    step8(1'b1, 1'b0, 3'd5, 8'h00);
    checks++; if (bus8.outp !== 8'h00 || bus8.out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL sel_gate got %h/%b want 00/1", bus8.outp, bus8.out_valid);
    end
  endtask

  task automatic test_clear_ignore();
    int n;
    rst8 = 1'b1;
    drive8(1'b1, 1'b1, 3'd2, 8'hF0);
    tick();
    rst8 = 1'b0;
    n = 0;
    while (bus8.busy === 1'b1 && n < 100) begin
      checks++; if (bus8.out_valid !== 1'b0 || bus8.err !== 1'b0 || bus8.outp !== 8'h00) begin
        errors++; $display("[TB] FAIL clear_quiet got %h/%b/%b want 00/0/0", bus8.outp, bus8.out_valid, bus8.err);
      end
      n++; tick();
    end
    checks++; if (n != 8) begin errors++; $display("[TB] FAIL clear_busy_len got %0d want 8", n); end
    clear_model8();
    step8(1'b1, 1'b0, 3'd2, 8'h00);
    checks++; if (bus8.outp !== 8'h00 || bus8.out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL clear_ignore got %h/%b want 00/1", bus8.outp, bus8.out_valid);
    end
  endtask

  task automatic test_reset_restart();
    int n;
    step8(1'b1, 1'b1, 3'd7, 8'h55);
    step8(1'b1, 1'b0, 3'd7, 8'h00);
    checks++; if (bus8.outp !== 8'h55) begin errors++; $display("[TB] FAIL restart_pre got %h want 55", bus8.outp); end
    rst8 = 1'b1;
    drive8(1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    rst8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus8.busy !== 1'b1) begin errors++; $display("[TB] FAIL restart_busy cyc=%0d got %b want 1", i, bus8.busy); end
      tick();
    end
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    n = 0;
    while (bus8.busy === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (n != 8) begin errors++; $display("[TB] FAIL restart_busy_len got %0d want 8", n); end
    clear_model8();
    step8(1'b1, 1'b0, 3'd7, 8'h00);
    checks++; if (bus8.outp !== 8'h00 || bus8.out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL restart_addr7 got %h/%b want 00/1", bus8.outp, bus8.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) step8(1'b1, 1'b1, 3'(i), 8'($urandom));
    for (int i = 0; i < 8; i++) begin
      step8(1'b1, 1'b0, 3'(i), 8'h00);
      checks++; if (bus8.outp !== exp_outp8 || bus8.out_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b_read addr=%0d got %h/%b want %h/1", i, bus8.outp, bus8.out_valid, exp_outp8);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step8(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 8'($urandom));
      checks++; if (bus8.outp !== exp_outp8 || bus8.out_valid !== exp_ov8 || bus8.err !== exp_err8) begin
        errors++; $display("[TB] FAIL rand_access i=%0d got %h/%b/%b want %h/%b/%b", i,
                           bus8.outp, bus8.out_valid, bus8.err, exp_outp8, exp_ov8, exp_err8);
      end
    end
  endtask

  task automatic test_out_of_range();
    int n;
    rst6 = 1'b1;
    drive6(1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    rst6 = 1'b0;
    n = 0;
    while (bus6.busy === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (n != 6) begin errors++; $display("[TB] FAIL d6_busy_len got %0d want 6", n); end
    for (int i = 0; i < 6; i++) model6[i] = 8'h00;
    exp_outp6 = 8'h00;
    for (int i = 0; i < 6; i++) step6(1'b1, 1'b1, 3'(i), 8'($urandom));
    step6(1'b1, 1'b1, 3'd6, 8'h11);
    checks++; if (bus6.err !== 1'b1 || bus6.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL oor_write got err=%b ov=%b want err=1 ov=0", bus6.err, bus6.out_valid);
    end
    step6(1'b1, 1'b0, 3'd5, 8'h00);
    step6(1'b1, 1'b0, 3'd6, 8'h00);
    checks++; if (bus6.err !== 1'b1 || bus6.out_valid !== 1'b1 || bus6.outp !== 8'h00) begin
      errors++; $display("[TB] FAIL oor_read got %h/%b/%b want 00/1/1", bus6.outp, bus6.out_valid, bus6.err);
    end
    step6(1'b0, 1'b0, 3'd0, 8'h00);
    checks++; if (bus6.err !== 1'b0 || bus6.out_valid !== 1'b0 || bus6.outp !== 8'h00) begin
      errors++; $display("[TB] FAIL oor_idle got %h/%b/%b want 00/0/0", bus6.outp, bus6.out_valid, bus6.err);
    end
    for (int i = 7; i >= 0; i--) begin
      step6(1'b1, 1'b0, 3'(i), 8'h00);
      checks++; if (bus6.outp !== exp_outp6 || bus6.out_valid !== exp_ov6 || bus6.err !== exp_err6) begin
        errors++; $display("[TB] FAIL d6_read addr=%0d got %h/%b/%b want %h/%b/%b", i,
                           bus6.outp, bus6.out_valid, bus6.err, exp_outp6, exp_ov6, exp_err6);
      end
    end
  endtask

  initial begin
    rst8 = 1'b1;
    rst6 = 1'b1;
    drive8(1'b0, 1'b0, 3'd0, 8'h00);
    drive6(1'b0, 1'b0, 3'd0, 8'h00);
    exp_outp8 = 8'h00; exp_ov8 = 1'b0; exp_err8 = 1'b0;
    exp_outp6 = 8'h00; exp_ov6 = 1'b0; exp_err6 = 1'b0;
    for (int i = 0; i < 8; i++) model8[i] = 8'h00;
    for (int i = 0; i < 6; i++) model6[i] = 8'h00;
    tick();
    test_reset();
    test_write_read();
    test_sel_gate();
    test_clear_ignore();
    test_reset_restart();
    test_back_to_back();
    test_random();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
